spi_byte_receiver: RTL and testbench

SPI slave front end that deserialises MOSI into bytes for the control message decoder and serialises a response byte onto MISO. It samples the external SPI pins (SPI mode 0, MSB first) with the system clock, so the system clock must run at least 8× SCLK. Each completed byte appears on `spi_byte` with a one-cycle `byte_valid` strobe. The decoder consumes `spi_byte` only in cycles where `byte_valid` is high.

---
 rtl/spi_pkg.sv | 14 +
 rtl/pin_synchronizer.sv | 30 +++
 rtl/spi_byte_receiver.sv | 142 ++++++++++++++
 tb/tb_spi_byte_receiver.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave byte receiver.
package spi_pkg;

    localparam int unsigned SPI_BYTE_W = 8;
    localparam int unsigned BIT_CNT_W  = 3;

    // Idle pin levels (SPI mode 0, deselected)
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic CS_N_IDLE = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;

    typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

endpackage : spi_pkg

// File: rtl/pin_synchronizer.sv
// N-stage flip-flop synchroniser for an asynchronous input pin, with a
// configurable reset level so the chain starts at the pin's idle value.
module pin_synchronizer #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], pin_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule : pin_synchronizer

// File: rtl/spi_byte_receiver.sv
// SPI mode-0 slave front end: oversamples the SPI pins with clk, deserialises
// MOSI into bytes and shifts a response byte out on MISO, MSB first.
module spi_byte_receiver
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_en,
    input  logic [SPI_BYTE_W-1:0] tx_byte,
    output logic [SPI_BYTE_W-1:0] spi_byte,
    output logic                  byte_valid,
    output logic                  frame_abort
);

    logic sclk_sync;
    logic cs_n_sync;
    logic mosi_sync;

    pin_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(SCLK_IDLE)) u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (sclk),
        .sync_o (sclk_sync)
    );

    pin_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(CS_N_IDLE)) u_sync_cs_n (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (cs_n),
        .sync_o (cs_n_sync)
    );

    pin_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(MOSI_IDLE)) u_sync_mosi (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (mosi),
        .sync_o (mosi_sync)
    );

    logic                  sclk_hist_q, sclk_hist_d;
    logic                  cs_n_hist_q, cs_n_hist_d;
    logic [SPI_BYTE_W-1:0] rx_shift_q,  rx_shift_d;
    logic [SPI_BYTE_W-1:0] tx_shift_q,  tx_shift_d;
    logic [SPI_BYTE_W-1:0] spi_byte_q,  spi_byte_d;
    bit_cnt_t              bit_cnt_q,   bit_cnt_d;
    logic                  byte_valid_q, byte_valid_d;
    logic                  frame_abort_q, frame_abort_d;
    logic                  miso_q,      miso_d;
    logic                  miso_en_q,   miso_en_d;

    logic selected_c;
    logic sclk_rise_c;
    logic sclk_fall_c;
    logic cs_rise_c;
    logic cs_fall_c;

    // SCLK edges only count while the synchronised chip select is low.
    always_comb begin
        selected_c  = ~cs_n_sync;
        sclk_rise_c = selected_c & sclk_sync & ~sclk_hist_q;
        sclk_fall_c = selected_c & ~sclk_sync & sclk_hist_q;
        cs_rise_c   = cs_n_sync & ~cs_n_hist_q;
        cs_fall_c   = ~cs_n_sync & cs_n_hist_q;
    end

    always_comb begin
        sclk_hist_d   = sclk_sync;
        cs_n_hist_d   = cs_n_sync;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        spi_byte_d    = spi_byte_q;
        bit_cnt_d     = bit_cnt_q;
        byte_valid_d  = 1'b0;
        frame_abort_d = 1'b0;
        miso_d        = tx_shift_q[SPI_BYTE_W-1];
        miso_en_d     = selected_c;

        // Receive path; a deselect takes priority over a coincident SCLK rise.
        if (cs_rise_c) begin
            bit_cnt_d     = '0;
            rx_shift_d    = '0;
            frame_abort_d = (bit_cnt_q != '0);
        end else if (sclk_rise_c) begin
            rx_shift_d = {rx_shift_q[SPI_BYTE_W-2:0], mosi_sync};
            bit_cnt_d  = bit_cnt_t'(bit_cnt_q + bit_cnt_t'(1));
            if (bit_cnt_q == bit_cnt_t'(SPI_BYTE_W - 1)) begin
                spi_byte_d   = {rx_shift_q[SPI_BYTE_W-2:0], mosi_sync};
                byte_valid_d = 1'b1;
            end
        end

        // Transmit path: reload at frame start and at the first fall of each byte.
        if (cs_fall_c) begin
            tx_shift_d = tx_byte;
        end else if (sclk_fall_c) begin
            if (bit_cnt_q == '0) begin
                tx_shift_d = tx_byte;
            end else begin
                tx_shift_d = {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_hist_q   <= SCLK_IDLE;
            cs_n_hist_q   <= CS_N_IDLE;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            spi_byte_q    <= '0;
            bit_cnt_q     <= '0;
            byte_valid_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            miso_q        <= 1'b0;
            miso_en_q     <= 1'b0;
        end else begin
            sclk_hist_q   <= sclk_hist_d;
            cs_n_hist_q   <= cs_n_hist_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            spi_byte_q    <= spi_byte_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_valid_q  <= byte_valid_d;
            frame_abort_q <= frame_abort_d;
            miso_q        <= miso_d;
            miso_en_q     <= miso_en_d;
        end
    end

    assign spi_byte    = spi_byte_q;
    assign byte_valid  = byte_valid_q;
    assign frame_abort = frame_abort_q;
    assign miso        = miso_q;
    assign miso_en     = miso_en_q;

endmodule : spi_byte_receiver

// File: tb/tb_spi_byte_receiver.sv
// Self-checking bench for spi_byte_receiver: SCLK = clk/8, expected bytes
// are queued as frames are driven and checked when byte_valid fires.
module tb_spi_byte_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_en;
    logic [7:0] tx_byte;
    logic [7:0] spi_byte;
    logic       byte_valid;
    logic       frame_abort;

    int         n_checks  = 0;
    int         n_pass    = 0;
    int         abort_cnt = 0;
    int         valid_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    logic       prev_valid = 1'b0;

    always #5 clk = ~clk;

    spi_byte_receiver #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_en     (miso_en),
        .tx_byte     (tx_byte),
        .spi_byte    (spi_byte),
        .byte_valid  (byte_valid),
        .frame_abort (frame_abort)
    );

    // Scoreboard monitor: every byte_valid pops one expected byte.
    always @(negedge clk) begin
        if (byte_valid === 1'b1) begin
            valid_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_valid: got spi_byte=%h, no byte expected", spi_byte);
            end else begin
                exp_b = exp_q.pop_front();
                if (spi_byte !== exp_b)
                    $display("FAIL rx_byte: got %h expected %h", spi_byte, exp_b);
                else
                    n_pass++;
            end
            n_checks++;
            if (prev_valid !== 1'b0)
                $display("FAIL valid_consecutive: got prev byte_valid=%b expected 0", prev_valid);
            else
                n_pass++;
        end
        if (frame_abort === 1'b1) abort_cnt++;
        prev_valid = byte_valid;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish within 50000 cycles");
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift nbits of b on MOSI, capturing MISO just before each SCLK rise.
    task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] miso_b);
        miso_b = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            wait_clk(4);
            miso_b[7-i] = miso;
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] miso_b);
        exp_q.push_back(b);
        spi_bits(b, 8, miso_b);
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_end();
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(6);
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 40) begin
            wait_clk(1);
            budget++;
        end
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drain: got %0d bytes outstanding expected 0", name, exp_q.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_byte = 8'h00;
        wait_clk(3);
        n_checks++;
        if ({spi_byte, byte_valid, frame_abort, miso, miso_en} !== 12'h000)
            $display("FAIL reset_outputs: got %h expected 000",
                     {spi_byte, byte_valid, frame_abort, miso, miso_en});
        else
            n_pass++;
        rst = 1'b0;
        wait_clk(4);
        n_checks++;
        if ({spi_byte, byte_valid, frame_abort, miso, miso_en} !== 12'h000)
            $display("FAIL idle_after_reset: got %h expected 000",
                     {spi_byte, byte_valid, frame_abort, miso, miso_en});
        else
            n_pass++;
    endtask

    task automatic test_idle_sclk();
        int a0, v0;
        a0 = abort_cnt; v0 = valid_cnt;
        for (int i = 0; i < 12; i++) begin
            mosi = 1'($urandom_range(0, 1));
            sclk = ~sclk;
            wait_clk(4);
        end
        sclk = 1'b0;
        wait_clk(4);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(4);
        n_checks++;
        if (valid_cnt !== v0) $display("FAIL idle_valid: got %0d expected %0d", valid_cnt, v0);
        else n_pass++;
        n_checks++;
        if (abort_cnt !== a0) $display("FAIL idle_abort: got %0d expected %0d", abort_cnt, a0);
        else n_pass++;
        n_checks++;
        if (spi_byte !== 8'h00) $display("FAIL idle_spi_byte: got %h expected 00", spi_byte);
        else n_pass++;
    endtask

    task automatic test_frame_bytes();
        int v0;
        logic [7:0] m;
        v0 = valid_cnt;
        cs_begin();
        send_byte(8'hFE, m);
        send_byte(8'h01, m);
        send_byte(8'hD2, m);
        cs_end();
        drain("frame");
        n_checks++;
        if (valid_cnt !== v0 + 3) $display("FAIL frame_valid_count: got %0d expected %0d", valid_cnt, v0 + 3);
        else n_pass++;
        n_checks++;
        if (spi_byte !== 8'hD2) $display("FAIL frame_hold: got %h expected d2", spi_byte);
        else n_pass++;
    endtask

    task automatic test_miso();
        logic [7:0] m;
        tx_byte = 8'hA5;
        cs_begin();
        n_checks++;
        if (miso_en !== 1'b1) $display("FAIL miso_en_selected: got %b expected 1", miso_en);
        else n_pass++;
        send_byte(8'h5A, m);
        n_checks++;
        if (m !== 8'hA5) $display("FAIL miso_byte0: got %h expected a5", m);
        else n_pass++;
        send_byte(8'h0F, m);
        n_checks++;
        if (m !== 8'hA5) $display("FAIL miso_byte1: got %h expected a5", m);
        else n_pass++;
        cs_end();
        n_checks++;
        if (miso_en !== 1'b0) $display("FAIL miso_en_deselected: got %b expected 0", miso_en);
        else n_pass++;
        drain("miso");
        tx_byte = 8'h00;
    endtask

    task automatic test_abort();
        int a0, v0;
        logic [7:0] m;
        a0 = abort_cnt; v0 = valid_cnt;
        cs_begin();
        spi_bits(8'hB7, 5, m);
        cs_end();
        n_checks++;
        if (abort_cnt !== a0 + 1) $display("FAIL abort_count: got %0d expected %0d", abort_cnt, a0 + 1);
        else n_pass++;
        n_checks++;
        if (valid_cnt !== v0) $display("FAIL abort_no_valid: got %0d expected %0d", valid_cnt, v0);
        else n_pass++;
        cs_begin();
        send_byte(8'h3C, m);
        cs_end();
        drain("after_abort");
        n_checks++;
        if (spi_byte !== 8'h3C) $display("FAIL after_abort_byte: got %h expected 3c", spi_byte);
        else n_pass++;
        n_checks++;
        if (abort_cnt !== a0 + 1) $display("FAIL full_byte_no_abort: got %0d expected %0d", abort_cnt, a0 + 1);
        else n_pass++;
    endtask

    task automatic test_rst_mid_byte();
        int a0, v0;
        logic [7:0] m;
        a0 = abort_cnt; v0 = valid_cnt;
        cs_begin();
        spi_bits(8'hFF, 4, m);
        rst = 1'b1;
        wait_clk(2);
        n_checks++;
        if ({spi_byte, byte_valid, frame_abort, miso, miso_en} !== 12'h000)
            $display("FAIL mid_reset_outputs: got %h expected 000",
                     {spi_byte, byte_valid, frame_abort, miso, miso_en});
        else
            n_pass++;
        cs_n = 1'b1; sclk = 1'b0;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(2);
        cs_begin();
        send_byte(8'h81, m);
        cs_end();
        drain("rst_mid");
        n_checks++;
        if (valid_cnt !== v0 + 1) $display("FAIL rst_mid_valid_count: got %0d expected %0d", valid_cnt, v0 + 1);
        else n_pass++;
        n_checks++;
        if (abort_cnt !== a0) $display("FAIL rst_mid_abort: got %0d expected %0d", abort_cnt, a0);
        else n_pass++;
        n_checks++;
        if (spi_byte !== 8'h81) $display("FAIL rst_mid_byte: got %h expected 81", spi_byte);
        else n_pass++;
    endtask

    task automatic test_cs_coincident();
        int a0, v0;
        logic [7:0] m;
        a0 = abort_cnt; v0 = valid_cnt;
        cs_begin();
        spi_bits(8'h6E, 7, m);
        mosi = 1'b0;
        wait_clk(4);
        sclk = 1'b1;
        cs_n = 1'b1;
        wait_clk(8);
        sclk = 1'b0;
        wait_clk(6);
        n_checks++;
        if (abort_cnt !== a0 + 1) $display("FAIL coincident_abort: got %0d expected %0d", abort_cnt, a0 + 1);
        else n_pass++;
        n_checks++;
        if (valid_cnt !== v0) $display("FAIL coincident_valid: got %0d expected %0d", valid_cnt, v0);
        else n_pass++;
        n_checks++;
        if (spi_byte !== 8'h81) $display("FAIL coincident_hold: got %h expected 81", spi_byte);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle_sclk();
        test_frame_bytes();
        test_miso();
        test_abort();
        test_rst_mid_byte();
        test_cs_coincident();
        wait_clk(4);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL final_queue: got %0d bytes outstanding expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_spi_byte_receiver
